// File: rtl/full_adder_cell_pkg.sv
// Shared constants for the full_adder_cell slice.
// Legal operand widths for the ripple adder cell.
package full_adder_cell_pkg;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 64;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder_cell.sv
// Ripple-carry adder of WIDTH full_adder_bit cells with a registered
// output stage and valid flag.
module full_adder_cell
    import full_adder_cell_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid
);

    localparam bit WIDTH_LEGAL = width_ok(WIDTH);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    // Only the carry out of the top bit is exposed.
    assign cout = carry[WIDTH] & WIDTH_LEGAL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= sum;
                cout_q <= cout;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_cell.sv
// Self-checking bench for full_adder_cell at WIDTH = 1, 8 and 33.
module tb_full_adder_cell;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a1, b1, cin1, iv1;
    logic        s1, c1, sq1, cq1, ov1;
    logic [7:0]  a8, b8, s8, sq8;
    logic        cin8, iv8, c8, cq8, ov8;
    logic [32:0] a33, b33, s33, sq33;
    logic        cin33, iv33, c33, cq33, ov33;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    full_adder_cell #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
        .in_valid(iv1), .sum(s1), .cout(c1), .sum_q(sq1),
        .cout_q(cq1), .out_valid(ov1)
    );

    full_adder_cell #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
        .in_valid(iv8), .sum(s8), .cout(c8), .sum_q(sq8),
        .cout_q(cq8), .out_valid(ov8)
    );

    full_adder_cell #(.WIDTH(33)) dut33 (
        .clk(clk), .rst_n(rst_n), .a(a33), .b(b33), .cin(cin33),
        .in_valid(iv33), .sum(s33), .cout(c33), .sum_q(sq33),
        .cout_q(cq33), .out_valid(ov33)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        {a1, b1, cin1, iv1} = 4'b0;
        a8 = 8'h69; b8 = 8'hB6; cin8 = 1'b0; iv8 = 1'b1;
        a33 = '0; b33 = '0; cin33 = 1'b0; iv33 = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({sq8, cq8, ov8} !== 10'b0) begin
            fails++;
            $display("FAIL reset_w8: got sq=%h cq=%b ov=%b want 0",
                     sq8, cq8, ov8);
        end
        checks++;
        if ({sq1, cq1, ov1, sq33, cq33, ov33} !== 38'b0) begin
            fails++;
            $display("FAIL reset_w1_w33: got %b %b %b %h %b %b want 0",
                     sq1, cq1, ov1, sq33, cq33, ov33);
        end
        checks++;
        if ({c8, s8} !== 9'h11F) begin
            fails++;
            $display("FAIL comb_in_reset: got %h want 11f", {c8, s8});
        end
        rst_n = 1'b1;
        iv8 = 1'b0;
        iv33 = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [1:0] e;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {a1, b1, cin1} = v;
            iv1 = 1'b1;
            e = 2'(a1) + 2'(b1) + 2'(cin1);
            #1;
            checks++;
            if ({c1, s1} !== e) begin
                fails++;
                $display("FAIL tt_comb %b: got %b want %b", v, {c1, s1}, e);
            end
            step();
            checks++;
            if ({cq1, sq1, ov1} !== {e, 1'b1}) begin
                fails++;
                $display("FAIL tt_reg %b: got %b want %b",
                         v, {cq1, sq1, ov1}, {e, 1'b1});
            end
        end
    endtask

    task automatic test_vectors8();
        logic [7:0] ta [3] = '{8'h69, 8'h0A, 8'hFF};
        logic [7:0] tb [3] = '{8'hB6, 8'h57, 8'h00};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [8:0] te [3] = '{9'h11F, 9'h061, 9'h100};
        for (int i = 0; i < 3; i++) begin
            a8 = ta[i]; b8 = tb[i]; cin8 = tc[i]; iv8 = 1'b1;
            #1;
            checks++;
            if ({c8, s8} !== te[i]) begin
                fails++;
                $display("FAIL vec8_comb %0d: got %h want %h",
                         i, {c8, s8}, te[i]);
            end
            step();
            checks++;
            if ({cq8, sq8, ov8} !== {te[i], 1'b1}) begin
                fails++;
                $display("FAIL vec8_reg %0d: got %h want %h",
                         i, {cq8, sq8, ov8}, {te[i], 1'b1});
            end
        end
    endtask

    task automatic test_valid_pattern();
        a8 = 8'h0A; b8 = 8'h57; cin8 = 1'b0; iv8 = 1'b1;
        step();
        checks++;
        if ({ov8, cq8, sq8} !== {1'b1, 9'h061}) begin
            fails++;
            $display("FAIL vp_edge1: got %h want %h",
                     {ov8, cq8, sq8}, {1'b1, 9'h061});
        end
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; iv8 = 1'b0;
        step();
        checks++;
        if ({ov8, cq8, sq8} !== {1'b0, 9'h061}) begin
            fails++;
            $display("FAIL vp_hold: got %h want %h",
                     {ov8, cq8, sq8}, {1'b0, 9'h061});
        end
        iv8 = 1'b1;
        step();
        checks++;
        if ({ov8, cq8, sq8} !== {1'b1, 9'h100}) begin
            fails++;
            $display("FAIL vp_edge3: got %h want %h",
                     {ov8, cq8, sq8}, {1'b1, 9'h100});
        end
    endtask

    task automatic test_async_reset();
        a8 = 8'h69; b8 = 8'hB6; cin8 = 1'b0; iv8 = 1'b1;
        step();
        checks++;
        if ({ov8, cq8, sq8} !== {1'b1, 9'h11F}) begin
            fails++;
            $display("FAIL ar_pre: got %h want %h",
                     {ov8, cq8, sq8}, {1'b1, 9'h11F});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ov8, cq8, sq8} !== 10'b0) begin
            fails++;
            $display("FAIL ar_drop: got %h want 0", {ov8, cq8, sq8});
        end
        checks++;
        if ({c8, s8} !== 9'h11F) begin
            fails++;
            $display("FAIL ar_comb1: got %h want 11f", {c8, s8});
        end
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1;
        #1;
        checks++;
        if ({c8, s8} !== 9'h031) begin
            fails++;
            $display("FAIL ar_comb2: got %h want 031", {c8, s8});
        end
        step();
        checks++;
        if ({ov8, cq8, sq8} !== 10'b0) begin
            fails++;
            $display("FAIL ar_held: got %h want 0", {ov8, cq8, sq8});
        end
        rst_n = 1'b1;
        iv8 = 1'b0;
        step();
        checks++;
        if ({ov8, cq8, sq8} !== 10'b0) begin
            fails++;
            $display("FAIL ar_release: got %h want 0", {ov8, cq8, sq8});
        end
        iv8 = 1'b1;
        step();
        checks++;
        if ({ov8, cq8, sq8} !== {1'b1, 9'h031}) begin
            fails++;
            $display("FAIL ar_recap: got %h want %h",
                     {ov8, cq8, sq8}, {1'b1, 9'h031});
        end
    endtask

    task automatic test_random();
        logic [1:0]  e1, h1;
        logic [8:0]  e8, h8;
        logic [33:0] e33, h33;
        logic [63:0] r;
        int bad = 0;
        h1 = '0; h8 = '0; h33 = '0;
        for (int i = 0; i < 10000; i++) begin
            r = {$urandom(), $urandom()};
            {a1, b1, cin1} = r[2:0];
            a8 = r[15:8]; b8 = r[23:16]; cin8 = r[24];
            a33 = r[32:0];
            r = {$urandom(), $urandom()};
            b33 = r[32:0]; cin33 = r[40];
            iv1  = (i == 0) || ($urandom_range(0, 3) != 0);
            iv8  = (i == 0) || ($urandom_range(0, 3) != 0);
            iv33 = (i == 0) || ($urandom_range(0, 3) != 0);
            e1  = 2'(a1) + 2'(b1) + 2'(cin1);
            e8  = 9'(a8) + 9'(b8) + 9'(cin8);
            e33 = 34'(a33) + 34'(b33) + 34'(cin33);
            if (iv1)  h1 = e1;
            if (iv8)  h8 = e8;
            if (iv33) h33 = e33;
            #1;
            checks++;
            if ({c1, s1} !== e1 || {c8, s8} !== e8 || {c33, s33} !== e33) begin
                fails++;
                if (bad++ < 10)
                    $display("FAIL rnd_comb %0d: got %b %h %h want %b %h %h",
                             i, {c1, s1}, {c8, s8}, {c33, s33}, e1, e8, e33);
            end
            step();
            checks++;
            if ({cq1, sq1} !== h1 || ov1 !== iv1 ||
                {cq8, sq8} !== h8 || ov8 !== iv8 ||
                {cq33, sq33} !== h33 || ov33 !== iv33) begin
                fails++;
                if (bad++ < 10)
                    $display("FAIL rnd_reg %0d: got %b %h %h ov %b%b%b want %b %h %h ov %b%b%b",
                             i, {cq1, sq1}, {cq8, sq8}, {cq33, sq33},
                             ov1, ov8, ov33, h1, h8, h33, iv1, iv8, iv33);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_vectors8();
        test_valid_pattern();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
